// File: rtl/wb_commit_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_commit_arbiter_pkg
// Shared constants and types for the writeback commit arbiter: requester
// index assignments, field widths, the packed beat record carried from an
// execute unit to the writeback port, and the round-robin wrap helper.
// Optional feature macro used by the slice: WB_ARB_PERF_EN (stall counters).
// -----------------------------------------------------------------------------
package wb_commit_arbiter_pkg;

    localparam int NUM_REQS     = 5;
    localparam int NUM_WB_REQS  = NUM_REQS;
    localparam int NUM_THREADS  = 4;
    localparam int NW_BITS      = 2;
    localparam int NR_BITS      = 5;
    localparam int UUID_BITS    = 44;
    localparam int PERF_BITS    = 44;
    localparam int DATA_BITS    = NUM_THREADS * 32;
    localparam int REQ_IDX_BITS = $clog2(NUM_WB_REQS);

    // Requester slots on the writeback port.
    localparam int WB_REQ_ALU = 0;
    localparam int WB_REQ_LSU = 1;
    localparam int WB_REQ_CSR = 2;
    localparam int WB_REQ_FPU = 3;
    localparam int WB_REQ_GPU = 4;

    typedef logic [REQ_IDX_BITS-1:0] req_idx_t;

    typedef struct packed {
        logic [UUID_BITS-1:0]   uuid;
        logic [NW_BITS-1:0]     wid;
        logic [31:0]            pc;
        logic [NUM_THREADS-1:0] tmask;
        logic [NR_BITS-1:0]     rd;
        logic [DATA_BITS-1:0]   data;
        logic                   eop;
    } wb_beat_t;

    // Index reached by stepping 'offset' slots past 'base', wrapping at
    // NUM_WB_REQS (the requester count is not a power of two).
    function automatic req_idx_t rr_wrap(input req_idx_t base, input int offset);
        int sum;
        sum = int'(base) + offset;
        return req_idx_t'(sum % NUM_WB_REQS);
    endfunction

endpackage

// File: rtl/wb_commit_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_commit_arbiter_if
// Bundle of the execute-unit request lanes (flattened per requester) and the
// registered writeback output with its valid/ready handshake.
//   master : execute units + writeback consumer (drive req_*, wb_ready)
//   slave  : the arbiter (drives req_ready, wb_*, perf_stalls)
// perf_stalls exists only when WB_ARB_PERF_EN is defined.
// -----------------------------------------------------------------------------
interface wb_commit_arbiter_if;
    import wb_commit_arbiter_pkg::*;

    logic [NUM_REQS-1:0]             req_valid;
    logic [NUM_REQS-1:0]             req_ready;
    logic [NUM_REQS*UUID_BITS-1:0]   req_uuid;
    logic [NUM_REQS*NW_BITS-1:0]     req_wid;
    logic [NUM_REQS*32-1:0]          req_pc;
    logic [NUM_REQS*NUM_THREADS-1:0] req_tmask;
    logic [NUM_REQS*NR_BITS-1:0]     req_rd;
    logic [NUM_REQS*DATA_BITS-1:0]   req_data;
    logic [NUM_REQS-1:0]             req_eop;

    logic                            wb_valid;
    logic                            wb_ready;
    logic [UUID_BITS-1:0]            wb_uuid;
    logic [NW_BITS-1:0]              wb_wid;
    logic [31:0]                     wb_pc;
    logic [NUM_THREADS-1:0]          wb_tmask;
    logic [NR_BITS-1:0]              wb_rd;
    logic [DATA_BITS-1:0]            wb_data;
    logic                            wb_eop;

`ifdef WB_ARB_PERF_EN
    logic [NUM_REQS*PERF_BITS-1:0]   perf_stalls;

    modport master (
        output req_valid, req_uuid, req_wid, req_pc, req_tmask, req_rd, req_data, req_eop,
        output wb_ready,
        input  req_ready,
        input  wb_valid, wb_uuid, wb_wid, wb_pc, wb_tmask, wb_rd, wb_data, wb_eop,
        input  perf_stalls
    );

    modport slave (
        input  req_valid, req_uuid, req_wid, req_pc, req_tmask, req_rd, req_data, req_eop,
        input  wb_ready,
        output req_ready,
        output wb_valid, wb_uuid, wb_wid, wb_pc, wb_tmask, wb_rd, wb_data, wb_eop,
        output perf_stalls
    );
`else
    modport master (
        output req_valid, req_uuid, req_wid, req_pc, req_tmask, req_rd, req_data, req_eop,
        output wb_ready,
        input  req_ready,
        input  wb_valid, wb_uuid, wb_wid, wb_pc, wb_tmask, wb_rd, wb_data, wb_eop
    );

    modport slave (
        input  req_valid, req_uuid, req_wid, req_pc, req_tmask, req_rd, req_data, req_eop,
        input  wb_ready,
        output req_ready,
        output wb_valid, wb_uuid, wb_wid, wb_pc, wb_tmask, wb_rd, wb_data, wb_eop
    );
`endif

endinterface

// File: rtl/wb_commit_arbiter_rr.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
// Combinational grant selection for the writeback port.
//   req_i       : per-requester beat valid
//   rr_ptr_i    : last requester that completed a packet
//   lock_vld_i  : a multi-beat packet is in progress
//   lock_idx_i  : owner of the packet in progress
//   grant_o     : one-hot grant
//   grant_idx_o : encoded grant
//   grant_vld_o : some requester holds the grant
// While locked the owner keeps the grant even with its valid low, so a gap
// in a packet idles the port instead of letting another unit interleave.
// -----------------------------------------------------------------------------
module wb_rr_arbiter
    import wb_commit_arbiter_pkg::*;
(
    input  logic [NUM_WB_REQS-1:0] req_i,
    input  req_idx_t               rr_ptr_i,
    input  logic                   lock_vld_i,
    input  req_idx_t               lock_idx_i,
    output logic [NUM_WB_REQS-1:0] grant_o,
    output req_idx_t               grant_idx_o,
    output logic                   grant_vld_o
);

    req_idx_t cand;

    // NOTE: every output and temporary gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        cand        = '0;
        if (lock_vld_i) begin
            grant_vld_o = 1'b1;
            grant_idx_o = lock_idx_i;
        end else begin
            // Scan from the slot after the last packet winner; first hit wins.
            for (int k = 1; k <= NUM_WB_REQS; k++) begin
                cand = rr_wrap(rr_ptr_i, k);
                if (!grant_vld_o && req_i[cand]) begin
                    grant_vld_o = 1'b1;
                    grant_idx_o = cand;
                end
            end
        end
        grant_o[grant_idx_o] = grant_vld_o;
    end

endmodule

// File: rtl/wb_commit_arbiter.sv
// -----------------------------------------------------------------------------
// wb_commit_arbiter
// Merges the execute units (ALU, LSU, CSR, FPU, GPU) onto the single
// writeback port. Round-robin between packets, locked within a packet (held
// until eop), with one registered output beat under valid/ready.
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : wb_commit_arbiter_if.slave (request lanes, writeback output,
//           and perf_stalls when WB_ARB_PERF_EN is defined)
// Optional feature: WB_ARB_PERF_EN adds saturating per-requester stall
// counters (cycles with valid high and ready low).
// -----------------------------------------------------------------------------
module wb_commit_arbiter (
    input  logic                clk,
    input  logic                reset,
    wb_commit_arbiter_if.slave  bus
);
    import wb_commit_arbiter_pkg::*;

    wb_beat_t                 req_beat [NUM_WB_REQS];
    wb_beat_t                 wb_beat_q, wb_beat_d;
    logic                     wb_valid_q, wb_valid_d;
    logic                     lock_vld_q, lock_vld_d;
    req_idx_t                 lock_idx_q, lock_idx_d;
    req_idx_t                 rr_ptr_q, rr_ptr_d;

    logic [NUM_WB_REQS-1:0]   grant_oh;
    req_idx_t                 grant_idx;
    logic                     grant_vld;
    logic                     out_free;
    logic                     fire;

    // Slice the flattened request lanes into per-requester beats.
    always_comb begin
        for (int i = 0; i < NUM_WB_REQS; i++) begin
            req_beat[i].uuid  = bus.req_uuid [i*UUID_BITS   +: UUID_BITS];
            req_beat[i].wid   = bus.req_wid  [i*NW_BITS     +: NW_BITS];
            req_beat[i].pc    = bus.req_pc   [i*32          +: 32];
            req_beat[i].tmask = bus.req_tmask[i*NUM_THREADS +: NUM_THREADS];
            req_beat[i].rd    = bus.req_rd   [i*NR_BITS     +: NR_BITS];
            req_beat[i].data  = bus.req_data [i*DATA_BITS   +: DATA_BITS];
            req_beat[i].eop   = bus.req_eop  [i];
        end
    end

    wb_rr_arbiter u_arb (
        .req_i       (bus.req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .lock_vld_i  (lock_vld_q),
        .lock_idx_i  (lock_idx_q),
        .grant_o     (grant_oh),
        .grant_idx_o (grant_idx),
        .grant_vld_o (grant_vld)
    );

    // The output slot can take a beat when empty or draining this cycle.
    // Ready is held low during reset so nothing is accepted then.
    assign out_free      = !wb_valid_q || bus.wb_ready;
    assign bus.req_ready = (grant_vld && out_free && !reset) ? grant_oh : '0;
    assign fire          = grant_vld && out_free && !reset && bus.req_valid[grant_idx];

    // Next state: a fire replaces the output beat (even one draining now);
    // only a completing beat moves the fairness pointer.
    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_beat_d  = wb_beat_q;
        lock_vld_d = lock_vld_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        if (fire) begin
            wb_valid_d = 1'b1;
            wb_beat_d  = req_beat[grant_idx];
            if (req_beat[grant_idx].eop) begin
                lock_vld_d = 1'b0;
                rr_ptr_d   = grant_idx;
            end else begin
                lock_vld_d = 1'b1;
                lock_idx_d = grant_idx;
            end
        end else if (bus.wb_ready) begin
            wb_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            // NOTE: the wide data register is cleared as well so the port
            // shows all-zero fields after reset; a plain datapath register
            // would normally be left unreset.
            wb_beat_q  <= '0;
            lock_vld_q <= 1'b0;
            lock_idx_q <= '0;
            rr_ptr_q   <= req_idx_t'(NUM_WB_REQS - 1);
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_beat_q  <= wb_beat_d;
            lock_vld_q <= lock_vld_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_uuid  = wb_beat_q.uuid;
    assign bus.wb_wid   = wb_beat_q.wid;
    assign bus.wb_pc    = wb_beat_q.pc;
    assign bus.wb_tmask = wb_beat_q.tmask;
    assign bus.wb_rd    = wb_beat_q.rd;
    assign bus.wb_data  = wb_beat_q.data;
    assign bus.wb_eop   = wb_beat_q.eop;

`ifdef WB_ARB_PERF_EN
    logic [PERF_BITS-1:0] perf_q [NUM_WB_REQS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_WB_REQS; i++) begin
                perf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_WB_REQS; i++) begin
                // Saturate instead of wrapping.
                if (bus.req_valid[i] && !bus.req_ready[i] && perf_q[i] != '1) begin
                    perf_q[i] <= perf_q[i] + PERF_BITS'(1);
                end
            end
        end
    end

    always_comb begin
        bus.perf_stalls = '0;
        for (int i = 0; i < NUM_WB_REQS; i++) begin
            bus.perf_stalls[i*PERF_BITS +: PERF_BITS] = perf_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_commit_arbiter
// Directed scenarios followed by a randomized run, all compared each cycle
// against a behavioural model of the writeback port (priority list rotated
// past the last packet winner, packet ownership, one output slot).
// Honours WB_ARB_PERF_EN for the stall counters.
// -----------------------------------------------------------------------------
module tb_wb_commit_arbiter;
    import wb_commit_arbiter_pkg::*;

    logic clk;
    logic rst;
    logic wb_rdy;

    // Per-requester stimulus.
    logic [NUM_REQS-1:0]    r_valid;
    logic [NUM_REQS-1:0]    r_eop;
    logic [UUID_BITS-1:0]   r_uuid  [NUM_REQS];
    logic [NW_BITS-1:0]     r_wid   [NUM_REQS];
    logic [31:0]            r_pc    [NUM_REQS];
    logic [NUM_THREADS-1:0] r_tmask [NUM_REQS];
    logic [NR_BITS-1:0]     r_rd    [NUM_REQS];
    logic [DATA_BITS-1:0]   r_data  [NUM_REQS];

    // Reference model state.
    bit                     m_valid;
    bit                     m_locked;
    int                     m_owner;
    int                     m_last;
    logic [UUID_BITS-1:0]   m_uuid;
    logic [NW_BITS-1:0]     m_wid;
    logic [31:0]            m_pc;
    logic [NUM_THREADS-1:0] m_tmask;
    logic [NR_BITS-1:0]     m_rd;
    logic [DATA_BITS-1:0]   m_data;
    logic                   m_eop;
    logic [PERF_BITS-1:0]   m_stall [NUM_REQS];

    int    dlog[$];   // requester indices the DUT accepted, in order
    int    n_cmp;
    int    n_err;
    string phase;

    wb_commit_arbiter_if bus ();

    wb_commit_arbiter dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s.%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic drive_bus();
        bus.req_valid = r_valid;
        bus.req_eop   = r_eop;
        bus.wb_ready  = wb_rdy;
        for (int i = 0; i < NUM_REQS; i++) begin
            bus.req_uuid [i*UUID_BITS   +: UUID_BITS]   = r_uuid[i];
            bus.req_wid  [i*NW_BITS     +: NW_BITS]     = r_wid[i];
            bus.req_pc   [i*32          +: 32]          = r_pc[i];
            bus.req_tmask[i*NUM_THREADS +: NUM_THREADS] = r_tmask[i];
            bus.req_rd   [i*NR_BITS     +: NR_BITS]     = r_rd[i];
            bus.req_data [i*DATA_BITS   +: DATA_BITS]   = r_data[i];
        end
    endtask

    task automatic model_reset();
        m_valid  = 0;
        m_locked = 0;
        m_owner  = 0;
        m_last   = NUM_REQS - 1;
        m_uuid   = '0;
        m_wid    = '0;
        m_pc     = '0;
        m_tmask  = '0;
        m_rd     = '0;
        m_data   = '0;
        m_eop    = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) m_stall[i] = '0;
    endtask

    // Who owns the port this cycle: the packet owner if a packet is open,
    // otherwise the first valid unit in the priority list that starts just
    // after the last unit to finish a packet.
    task automatic model_pick(output int g, output bit has);
        int order[$];
        g   = 0;
        has = 0;
        if (m_locked) begin
            g   = m_owner;
            has = 1;
        end else begin
            for (int k = 0; k < NUM_REQS; k++) order.push_back((m_last + 1 + k) % NUM_REQS);
            foreach (order[j]) begin
                if (!has && r_valid[order[j]]) begin
                    g   = order[j];
                    has = 1;
                end
            end
        end
    endtask

    // One clock: drive inputs, check ready before the edge, advance the
    // model across the edge, check the registered outputs after it.
    task automatic step();
        int                  g;
        bit                  has;
        bit                  free;
        bit                  fire;
        logic [NUM_REQS-1:0] exp_rdy;
        logic [NUM_REQS-1:0] acc;
        drive_bus();
        #1;
        model_pick(g, has);
        free    = !m_valid || wb_rdy;
        exp_rdy = '0;
        if (!rst && has && free) exp_rdy[g] = 1'b1;
        check("req_ready", 128'(bus.req_ready), 128'(exp_rdy));
        acc = bus.req_ready & r_valid;
        for (int i = 0; i < NUM_REQS; i++) if (acc[i]) dlog.push_back(i);
        fire = has && exp_rdy[g] && r_valid[g];
        if (!rst) begin
            for (int i = 0; i < NUM_REQS; i++)
                if (r_valid[i] && !exp_rdy[i] && m_stall[i] != '1) m_stall[i] = m_stall[i] + 1;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else if (fire) begin
            m_valid = 1;
            m_uuid  = r_uuid[g];
            m_wid   = r_wid[g];
            m_pc    = r_pc[g];
            m_tmask = r_tmask[g];
            m_rd    = r_rd[g];
            m_data  = r_data[g];
            m_eop   = r_eop[g];
            if (r_eop[g]) begin
                m_locked = 0;
                m_last   = g;
            end else begin
                m_locked = 1;
                m_owner  = g;
            end
        end else if (wb_rdy) begin
            m_valid = 0;
        end
        check("wb_valid", 128'(bus.wb_valid), 128'(m_valid));
        check("wb_uuid",  128'(bus.wb_uuid),  128'(m_uuid));
        check("wb_wid",   128'(bus.wb_wid),   128'(m_wid));
        check("wb_pc",    128'(bus.wb_pc),    128'(m_pc));
        check("wb_tmask", 128'(bus.wb_tmask), 128'(m_tmask));
        check("wb_rd",    128'(bus.wb_rd),    128'(m_rd));
        check("wb_data",  bus.wb_data,        m_data);
        check("wb_eop",   128'(bus.wb_eop),   128'(m_eop));
`ifdef WB_ARB_PERF_EN
        for (int i = 0; i < NUM_REQS; i++)
            check($sformatf("perf%0d", i), 128'(bus.perf_stalls[i*PERF_BITS +: PERF_BITS]), 128'(m_stall[i]));
`endif
        @(negedge clk);
    endtask

    task automatic randomize_fields();
        for (int i = 0; i < NUM_REQS; i++) begin
            r_uuid[i]  = UUID_BITS'({$urandom(), $urandom()});
            r_wid[i]   = NW_BITS'($urandom());
            r_pc[i]    = $urandom();
            r_tmask[i] = ($urandom_range(0, 5) == 0) ? '0 : NUM_THREADS'($urandom());
            r_rd[i]    = NR_BITS'($urandom());
            r_data[i]  = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        r_valid = '0;
        r_eop   = '1;
        wb_rdy  = 1'b1;
        step();
        step();
        rst = 1'b0;
        dlog.delete();
    endtask

    initial begin
        int cnt[NUM_REQS];
        logic [NR_BITS-1:0] keep_rd;
        n_cmp   = 0;
        n_err   = 0;
        phase   = "init";
        rst     = 1'b1;
        wb_rdy  = 1'b1;
        r_valid = '0;
        r_eop   = '1;
        randomize_fields();
        for (int i = 0; i < NUM_REQS; i++) r_rd[i] = NR_BITS'(i + 3);
        model_reset();
        drive_bus();
        @(negedge clk);

        // Reset defaults: all output fields zero, nothing ready.
        phase = "reset";
        do_reset();
        check("valid_after_reset", 128'(bus.wb_valid), 128'(0));
        check("rd_after_reset", 128'(bus.wb_rd), 128'(0));

        // ALU then LSU, each visible one cycle after its fire.
        phase = "reset_default";
        r_valid = 5'b00011;
        r_eop   = '1;
        step();
        check("first_rd_alu", 128'(bus.wb_rd), 128'(5'd3));
        step();
        check("second_rd_lsu", 128'(bus.wb_rd), 128'(5'd4));
        check("grants", 128'(dlog.size() == 2 && dlog[0] == 0 && dlog[1] == 1), 128'(1));

        // Round-robin fairness over 100 single-beat packets.
        phase = "fairness";
        do_reset();
        r_valid = '1;
        r_eop   = '1;
        for (int c = 0; c < 100; c++) step();
        foreach (cnt[i]) cnt[i] = 0;
        foreach (dlog[j]) cnt[dlog[j]]++;
        for (int i = 0; i < NUM_REQS; i++) check($sformatf("beats%0d", i), 128'(cnt[i]), 128'(20));
        check("order", 128'(dlog[0] == 0 && dlog[1] == 1 && dlog[2] == 2 && dlog[3] == 3
                            && dlog[4] == 4 && dlog[5] == 0), 128'(1));

        // LSU 3-beat packet holds the port while ALU waits.
        phase = "packet_lock";
        do_reset();
        r_valid = 5'b00001;
        step();
        r_valid = 5'b00011;
        r_eop   = 5'b11101;
        r_rd[1] = 5'd20; step();
        check("beat0_rd", 128'(bus.wb_rd), 128'(5'd20));
        r_rd[1] = 5'd21; step();
        check("beat1_rd", 128'(bus.wb_rd), 128'(5'd21));
        r_eop   = '1;
        r_rd[1] = 5'd22; step();
        check("beat2_rd", 128'(bus.wb_rd), 128'(5'd22));
        r_valid = 5'b00001;
        step();
        check("grants", 128'(dlog.size() == 5 && dlog[1] == 1 && dlog[2] == 1
                             && dlog[3] == 1 && dlog[4] == 0), 128'(1));
        r_rd[1] = 5'd4;

        // Backpressure: outputs hold, ready low, FPU stalls counted.
        phase = "backpressure";
        do_reset();
        r_valid = 5'b01000;
        r_eop   = '1;
        step();
        keep_rd = r_rd[3];
        wb_rdy  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("ready_low", 128'(bus.req_ready), 128'(0));
            check("rd_hold", 128'(bus.wb_rd), 128'(keep_rd));
            check("valid_hold", 128'(bus.wb_valid), 128'(1));
        end
`ifdef WB_ARB_PERF_EN
        check("fpu_stalls", 128'(bus.perf_stalls[3*PERF_BITS +: PERF_BITS]), 128'(5));
`endif
        wb_rdy = 1'b1;
        step();
        check("fpu_again", 128'(dlog.size()), 128'(2));

        // Reset in the middle of a GPU packet discards lock and beat.
        phase = "reset_mid_packet";
        do_reset();
        r_valid = 5'b10000;
        r_eop   = 5'b01111;
        step();
        rst = 1'b1;
        step();
        check("valid_cleared", 128'(bus.wb_valid), 128'(0));
        rst     = 1'b0;
        r_valid = 5'b00100;
        r_eop   = '1;
        step();
        check("csr_granted", 128'(dlog[dlog.size() - 1]), 128'(2));
        check("csr_rd", 128'(bus.wb_rd), 128'(r_rd[2]));

        // GPU drops valid mid-packet: port idles, ALU kept out.
        phase = "gap";
        do_reset();
        r_valid = 5'b10000;
        r_eop   = 5'b01111;
        step();
        r_valid = 5'b00001;
        for (int c = 0; c < 2; c++) begin
            step();
            check("idle", 128'(bus.wb_valid), 128'(0));
        end
        r_valid = 5'b10001;
        step();
        r_eop   = '1;
        step();
        r_valid = 5'b00001;
        step();
        check("grants", 128'(dlog.size() == 4 && dlog[0] == 4 && dlog[1] == 4
                             && dlog[2] == 4 && dlog[3] == 0), 128'(1));

        // Randomized traffic, including all-zero thread masks.
        phase = "random";
        do_reset();
        for (int c = 0; c < 400; c++) begin
            randomize_fields();
            for (int i = 0; i < NUM_REQS; i++) begin
                r_valid[i] = ($urandom_range(0, 1) == 1);
                r_eop[i]   = ($urandom_range(0, 2) != 0);
            end
            wb_rdy = ($urandom_range(0, 3) != 0);
            rst    = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_commit_arbiter.md
# wb_commit_arbiter

Arbitrates the execute units (ALU, LSU, CSR, FPU, GPU) onto the single writeback port that feeds the GPR stage and the scoreboard release path in the issue stage. Grants are round-robin and locked per multi-beat packet (held until `eop`), so one instruction's writes are never interleaved with another's. The output stage is registered with a valid/ready handshake.

## Interface
- `NUM_REQS`, 5, number of execute-unit requesters; index 0 = ALU, 1 = LSU, 2 = CSR, 3 = FPU, 4 = GPU.
- `NUM_THREADS`, 4, lanes per beat.
- `NW_BITS`, 2, warp-id width.
- `NR_BITS`, 5, register-index width.
- `UUID_BITS`, 44, instruction uuid width.
- `PERF_BITS`, 44, stall counter width (only with `WB_ARB_PERF_EN`).
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQS  beat valid per requester.
- `req_ready`  out  NUM_REQS  beat accepted per requester.
- `req_uuid`  in  NUM_REQS*UUID_BITS  uuid per requester.
- `req_wid`  in  NUM_REQS*NW_BITS  warp id.
- `req_pc`  in  NUM_REQS*32  PC.
- `req_tmask`  in  NUM_REQS*NUM_THREADS  thread mask.
- `req_rd`  in  NUM_REQS*NR_BITS  destination register.
- `req_data`  in  NUM_REQS*NUM_THREADS*32  per-lane write data.
- `req_eop`  in  NUM_REQS  last beat of instruction.
- `wb_valid`  out  1  writeback beat valid.
- `wb_ready`  in  1  downstream accepts.
- `wb_uuid`, `wb_wid`, `wb_pc`, `wb_tmask`, `wb_rd`, `wb_data`, `wb_eop`  out  widths as for one requester  registered winning beat.
- `perf_stalls`  out  NUM_REQS*PERF_BITS  per-requester stall counts (only with `WB_ARB_PERF_EN`).

## Operation
- `out_free = !wb_valid || wb_ready`.
- **Locked mode** (`lock_vld = 1`): the grant is `lock_idx` only; other requesters see `req_ready = 0`.
- **Unlocked mode:** the grant is the first valid requester scanning from `rr_ptr+1` upward, modulo NUM_REQS.
- `req_ready[g] = out_free` for the granted index `g`; all other bits are 0. Ready may depend on `req_valid` (combinational grant).
- **Fire** (`req_valid[g] && req_ready[g]`):
  - Load all `wb_*` fields from requester `g`; set `wb_valid = 1`.
  - If `eop = 0`: set `lock_vld = 1`, `lock_idx = g`.
  - If `eop = 1`: clear `lock_vld`; set `rr_ptr = g`.
- `rr_ptr` updates only on `eop` fires. A locked packet therefore does not advance fairness until it completes.
- **No fire and `wb_ready`:** clear `wb_valid`. Data fields hold their last values.
- **Locked requester drops `req_valid` mid-packet:** the lock is held and the port idles. Other requesters are not granted.
- **`tmask` all zero:** forwarded unchanged. No filtering.

## Timing
- **Reset:**
  - Outputs: `wb_valid = 0`, all `wb_*` data fields = 0, `req_ready = 0` during reset.
  - State: `lock_vld = 0`, `rr_ptr = NUM_REQS-1`, so requester 0 has first priority.
  - Counters: `perf_stalls` = 0.
- **Reset mid-packet:** the lock and the pending output are discarded. No partial beat is emitted after reset.
- **Latency:** 1 cycle from fire to `wb_valid`.
- **Throughput:** 1 beat per cycle when `wb_ready` stays high.
- **Simultaneous fire and drain in one cycle:** the new beat replaces the old one. `wb_valid` stays 1.
- **Backpressure:** with `wb_valid && !wb_ready`, every `req_ready` is 0 and the `wb_*` outputs are stable.

## Configuration
- **`WB_ARB_PERF_EN` defined:**
  - Each `perf_stalls` slice increments when `req_valid[i] && !req_ready[i]`.
  - Counters saturate at all-ones.
  - The `perf_stalls` port is present.
- **Not defined:** the port and counters are absent. Arbitration behaviour is identical.

## Structure
- **Shared package:**
  - Requester index constants (`WB_REQ_ALU` … `WB_REQ_GPU`).
  - A packed beat struct typedef (uuid, wid, pc, tmask, rd, data, eop).
  - `NUM_WB_REQS`.
- **Sub-module `wb_rr_arbiter`:**
  - Inputs: request vector, `rr_ptr`, lock state.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.
- **Top level:** the output register, lock and pointer state, and the perf counters.

## Test plan
- **Reset default:** after reset, ALU and LSU both valid with `eop = 1` and `wb_ready = 1` → ALU is granted in the first cycle and LSU in the second; `wb_rd` follows the ALU rd then the LSU rd, each 1 cycle after its fire.
- **Round-robin fairness:** all 5 requesters continuously valid with single-beat packets → grant order 0,1,2,3,4,0,…; each requester receives exactly 20 beats in 100 cycles.
- **Packet lock:** LSU sends a 3-beat packet (`eop` = 0,0,1) while ALU is valid → the three LSU beats appear on consecutive cycles; ALU is granted on the 4th cycle.
- **Backpressure:** hold `wb_ready = 0` for 5 cycles with `wb_valid = 1` and FPU valid → `wb_*` outputs are unchanged and `req_ready` = 0; with `WB_ARB_PERF_EN`, the FPU `perf_stalls` count increases by 5.
- **Reset mid-packet:** assert `reset` after the 1st of 3 beats → `wb_valid` = 0 next cycle; after release, CSR valid is granted immediately with no residual lock.
- **Gap in a locked packet:** GPU drops `req_valid` for 2 cycles mid-packet while ALU is valid → ALU is not granted and the port stays idle; GPU resumes and completes.
